leve1_csr_access: RTL and testbench
===================================

LEVE1_CSR_ACCESS -- requirements
Module: leve1_csr_access

Interface
REQ-001 The block SHALL have one parameter: XLEN, default `XLEN (64), the CSR data width.
REQ-002 The block SHALL have the following ports:
- CLK  in  1  clock
- RSTn  in  1  reset; asynchronous, active-low
- REQ_VALID  in  1  CSR instruction request
- REQ_READY  out  1  block accepts a request
- REQ_FUNCT3  in  3  CSRRW/S/C and CSRRWI/SI/CI encoding
- REQ_CSR  in  12  CSR address
- REQ_RS1_IDX  in  5  rs1 index, or uimm5 for the immediate forms
- REQ_RS1_VAL  in  XLEN  rs1 register value
- REQ_RD_IDX  in  5  destination register index
- REQ_MODE  in  2  current privilege, `MODE_U/S/M
- CSR_RA  out  12  CSR read address
- CSR_RD  in  XLEN  CSR read data, valid one cycle after CSR_RA
- CSR_WCMD  out  2  `CSR_NONE/SET/CLEAR/WRITE
- CSR_WA  out  12  CSR write address
- CSR_WD  out  XLEN  write operand
- RSP_VALID  out  1  result valid
- RSP_READY  in  1  consumer accepts the result
- RSP_WE  out  1  rd writeback enable
- RSP_RD_IDX  out  5  rd index
- RSP_DATA  out  XLEN  old CSR value
- RSP_ILLEGAL  out  1  illegal-instruction exception
- RETIRE  out  1  one-cycle pulse per completed legal access

Function
REQ-003 The FSM SHALL have four states, IDLE, READ, WRITE and RESP; REQ_READY SHALL be 1 only in IDLE.
REQ-004 When REQ_VALID&REQ_READY, the block SHALL latch all REQ_* fields and then move to READ, WRITE or RESP as defined in REQ-005 to REQ-011.
REQ-005 The operand SHALL be REQ_RS1_VAL for funct3[2]=0, and zero-extended REQ_RS1_IDX (uimm5) for funct3[2]=1.
REQ-006 funct3 values 000 and 100 SHALL be illegal.
REQ-007 An access SHALL be illegal if REQ_CSR[9:8] > REQ_MODE.
REQ-008 An access SHALL be illegal if REQ_CSR[11:10]==2'b11 and a write is due.
REQ-009 A write SHALL be due for RW forms always, and for S/C forms only when REQ_RS1_IDX!=0.
REQ-010 Illegal access: IDLE->RESP directly, with RSP_ILLEGAL=1, RSP_WE=0, RSP_DATA=0; no CSR_WCMD other than `CSR_NONE is issued.
REQ-011 The CSRRW/CSRRWI forms with rd=0 SHALL skip READ (IDLE->WRITE), with RSP_WE=0 and RSP_DATA=0.
REQ-012 READ SHALL last 1 cycle and drive CSR_RA=latched CSR.
REQ-013 In the cycle after READ, CSR_RD SHALL be captured into RSP_DATA.
REQ-014 The write SHALL be issued in that same capture cycle (state WRITE), so the old value always precedes the write.
REQ-015 WRITE SHALL last exactly 1 cycle and drive CSR_WA=CSR, CSR_WD=operand, and CSR_WCMD=WRITE/SET/CLEAR per funct3[1:0].
REQ-016 If no write is due, WRITE SHALL drive `CSR_NONE.
REQ-017 CSR_WCMD SHALL be `CSR_NONE in every other state.
REQ-018 The set and clear arithmetic is done by the CSR file; this block SHALL NOT read-modify-write itself.
REQ-019 RESP SHALL hold RSP_* stable until RSP_READY, then return to IDLE.
REQ-020 RETIRE SHALL pulse in the RSP_VALID&RSP_READY cycle for legal accesses only.
REQ-021 RSP_WE SHALL be 1 iff the access is legal, rd!=0, and the READ state was used.
REQ-022 Latency (request handshake to RSP_VALID) SHALL be 3 cycles for the normal path, 2 cycles for the rd=0 RW path, and 1 cycle for an illegal access.
REQ-023 Back-to-back requests SHALL be accepted in the cycle after the response handshake at the earliest.
REQ-024 In IDLE, REQ_READY SHALL be 1 with CSR_RA=0 and CSR_WA=0.

Reset
REQ-025 Asserting RSTn low SHALL force IDLE asynchronously at any time, including mid-access.
REQ-026 During reset, REQ_READY SHALL be 0 and all other outputs SHALL be 0, with CSR_WCMD=`CSR_NONE.
REQ-027 A write interrupted by reset before WRITE is entered SHALL never be issued.
REQ-028 After RSTn deasserts, the first request SHALL be accepted on the first rising edge.

Structure
REQ-029 `CSR_* command codes, `MODE_* encodings and `XLEN SHALL come from defs.vh.
REQ-030 State and funct3 enums SHALL be placed in a shared package for reuse by the decoder.
REQ-031 No sub-module is required; the legality check MAY be a single function.

Verification
REQ-032 CSRRW csr=0x305, rs1=0x8000_0000, rd=5, mode=M, with mtvec=0x100:
- RSP_DATA=0x100, RSP_WE=1.
- CSR_WCMD=WRITE with CSR_WD=0x8000_0000 for exactly 1 cycle.
- RSP_VALID 3 cycles after accept.
REQ-033 CSRRSI csr=0x300, uimm=0x8: CSR_WCMD=SET, CSR_WD=0x8, and the returned value is the pre-set mstatus.
REQ-034 CSRRS csr=0xC00, rs1 idx=0, mode=U: no write is issued, RSP_DATA=cycle, RSP_ILLEGAL=0.
REQ-035 Illegality cases:
- CSRRW csr=0x300 in mode=S: RSP_ILLEGAL=1 after 1 cycle, no CSR_WCMD, no RETIRE.
- CSRRW csr=0xF14 in mode=M: RSP_ILLEGAL=1.
REQ-036 Hold RSP_READY=0 for 4 cycles: RSP_* remain stable, REQ_READY stays 0, and RETIRE pulses once on acceptance.
REQ-037 Assert RSTn low during WRITE: CSR_WCMD goes to `CSR_NONE immediately, the FSM returns to IDLE, and a new request completes normally.

Source files
------------

// File: rtl/leve1_csr_access_pkg.sv
// Shared CSR access definitions: write-command and privilege codes, data width,
// FSM state and funct3 enums, and the decode helpers used by the access block.
`ifndef LEVE1_DEFS_VH
`define LEVE1_DEFS_VH
`define XLEN 64
`define CSR_NONE 2'b00
`define CSR_SET 2'b01
`define CSR_CLEAR 2'b10
`define CSR_WRITE 2'b11
`define MODE_U 2'b00
`define MODE_S 2'b01
`define MODE_M 2'b11
`endif

package leve1_csr_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_e;

  // RW forms always write; S/C forms write only with a nonzero rs1/uimm index.
  function automatic logic write_due(input logic [2:0] funct3, input logic [4:0] rs1_idx);
    return (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
  endfunction

  function automatic logic access_illegal(input logic [2:0]  funct3,
                                          input logic [11:0] csr,
                                          input logic [1:0]  mode,
                                          input logic        wr_due);
    return (funct3[1:0] == 2'b00) || (csr[9:8] > mode) ||
           ((csr[11:10] == 2'b11) && wr_due);
  endfunction

  function automatic logic [1:0] wcmd_of(input logic [2:0] funct3, input logic wr_due);
    logic [1:0] cmd;
    cmd = `CSR_NONE;
    if (wr_due) begin
      case (funct3[1:0])
        2'b01:   cmd = `CSR_WRITE;
        2'b10:   cmd = `CSR_SET;
        2'b11:   cmd = `CSR_CLEAR;
        default: cmd = `CSR_NONE;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/leve1_csr_access.sv
// CSR instruction sequencer: legality check, synchronous CSR read of the old
// value, then a single-cycle write command toward the CSR file.
//
// state    | meaning
// ST_IDLE  | ready for a request, CSR buses parked at zero
// ST_READ  | CSR_RA driven, CSR file returns old value next cycle
// ST_WRITE | old value captured, write command issued for one cycle
// ST_RESP  | response held until RSP_READY
module leve1_csr_access
  import leve1_csr_access_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [2:0]      REQ_FUNCT3,
  input  logic [11:0]     REQ_CSR,
  input  logic [4:0]      REQ_RS1_IDX,
  input  logic [XLEN-1:0] REQ_RS1_VAL,
  input  logic [4:0]      REQ_RD_IDX,
  input  logic [1:0]      REQ_MODE,
  output logic [11:0]     CSR_RA,
  input  logic [XLEN-1:0] CSR_RD,
  output logic [1:0]      CSR_WCMD,
  output logic [11:0]     CSR_WA,
  output logic [XLEN-1:0] CSR_WD,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic            RSP_WE,
  output logic [4:0]      RSP_RD_IDX,
  output logic [XLEN-1:0] RSP_DATA,
  output logic            RSP_ILLEGAL,
  output logic            RETIRE
);

  state_e          state;
  logic [11:0]     csr_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] opnd_q;
  logic [1:0]      cmd_q;
  logic            we_q;
  logic            read_q;

  logic            req_due;
  logic            req_ill;
  logic            req_skip;
  logic [1:0]      req_cmd;
  logic [XLEN-1:0] req_opnd;

  always_comb begin
    req_due  = write_due(REQ_FUNCT3, REQ_RS1_IDX);
    req_ill  = access_illegal(REQ_FUNCT3, REQ_CSR, REQ_MODE, req_due);
    req_skip = (REQ_FUNCT3[1:0] == 2'b01) && (REQ_RD_IDX == 5'd0);
    req_cmd  = wcmd_of(REQ_FUNCT3, req_due);
    req_opnd = REQ_FUNCT3[2] ? XLEN'(REQ_RS1_IDX) : REQ_RS1_VAL;
  end

  // Gated by RSTn so ready is low during reset yet high on the first edge after release.
  assign REQ_READY = (state == ST_IDLE) && RSTn;
  assign RETIRE    = RSP_VALID && RSP_READY && !RSP_ILLEGAL;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= ST_IDLE;
      csr_q       <= '0;
      rd_q        <= '0;
      opnd_q      <= '0;
      cmd_q       <= `CSR_NONE;
      we_q        <= 1'b0;
      read_q      <= 1'b0;
      CSR_RA      <= '0;
      CSR_WCMD    <= `CSR_NONE;
      CSR_WA      <= '0;
      CSR_WD      <= '0;
      RSP_VALID   <= 1'b0;
      RSP_WE      <= 1'b0;
      RSP_RD_IDX  <= '0;
      RSP_DATA    <= '0;
      RSP_ILLEGAL <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            csr_q    <= REQ_CSR;
            rd_q     <= REQ_RD_IDX;
            opnd_q   <= req_opnd;
            cmd_q    <= req_cmd;
            read_q   <= !req_ill && !req_skip;
            we_q     <= !req_ill && !req_skip && (REQ_RD_IDX != 5'd0);
            RSP_DATA <= '0;
            if (req_ill) begin
              state       <= ST_RESP;
              RSP_VALID   <= 1'b1;
              RSP_ILLEGAL <= 1'b1;
              RSP_WE      <= 1'b0;
              RSP_RD_IDX  <= REQ_RD_IDX;
            end else if (req_skip) begin
              state    <= ST_WRITE;
              CSR_WCMD <= req_cmd;
              CSR_WA   <= REQ_CSR;
              CSR_WD   <= req_opnd;
            end else begin
              state  <= ST_READ;
              CSR_RA <= REQ_CSR;
            end
          end
        end
        ST_READ: begin
          state    <= ST_WRITE;
          CSR_RA   <= '0;
          CSR_WCMD <= cmd_q;
          CSR_WA   <= csr_q;
          CSR_WD   <= opnd_q;
        end
        ST_WRITE: begin
          // CSR_RD still holds the pre-write value here; the write lands on this edge.
          state       <= ST_RESP;
          RSP_DATA    <= read_q ? CSR_RD : '0;
          CSR_WCMD    <= `CSR_NONE;
          CSR_WA      <= '0;
          CSR_WD      <= '0;
          RSP_VALID   <= 1'b1;
          RSP_WE      <= we_q;
          RSP_RD_IDX  <= rd_q;
          RSP_ILLEGAL <= 1'b0;
        end
        ST_RESP: begin
          if (RSP_READY) begin
            state       <= ST_IDLE;
            RSP_VALID   <= 1'b0;
            RSP_WE      <= 1'b0;
            RSP_RD_IDX  <= '0;
            RSP_DATA    <= '0;
            RSP_ILLEGAL <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leve1_csr_access.sv
// Scoreboard bench for leve1_csr_access with a behavioural synchronous-read CSR file.
module tb_leve1_csr_access;
  localparam int XLEN = 64;
  localparam logic [1:0] C_NONE = 2'b00, C_SET = 2'b01, C_CLEAR = 2'b10, C_WRITE = 2'b11;
  localparam logic [1:0] M_U = 2'b00, M_S = 2'b01, M_M = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_csr;
  logic [4:0]      req_rs1_idx;
  logic [XLEN-1:0] req_rs1_val;
  logic [4:0]      req_rd_idx;
  logic [1:0]      req_mode;
  logic [11:0]     csr_ra;
  logic [XLEN-1:0] csr_rd;
  logic [1:0]      csr_wcmd;
  logic [11:0]     csr_wa;
  logic [XLEN-1:0] csr_wd;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_we;
  logic [4:0]      rsp_rd_idx;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_illegal;
  logic            retire;

  always #5 clk = ~clk;

  leve1_csr_access #(.XLEN(XLEN)) dut (
    .CLK(clk), .RSTn(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_FUNCT3(req_funct3),
    .REQ_CSR(req_csr), .REQ_RS1_IDX(req_rs1_idx), .REQ_RS1_VAL(req_rs1_val),
    .REQ_RD_IDX(req_rd_idx), .REQ_MODE(req_mode),
    .CSR_RA(csr_ra), .CSR_RD(csr_rd), .CSR_WCMD(csr_wcmd), .CSR_WA(csr_wa), .CSR_WD(csr_wd),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_WE(rsp_we), .RSP_RD_IDX(rsp_rd_idx),
    .RSP_DATA(rsp_data), .RSP_ILLEGAL(rsp_illegal), .RETIRE(retire)
  );

  logic [XLEN-1:0] csr_mem [4096];

  always @(posedge clk) begin
    csr_rd <= csr_mem[csr_ra];
    case (csr_wcmd)
      C_WRITE: csr_mem[csr_wa] <= csr_wd;
      C_SET:   csr_mem[csr_wa] <= csr_mem[csr_wa] | csr_wd;
      C_CLEAR: csr_mem[csr_wa] <= csr_mem[csr_wa] & ~csr_wd;
      default: ;
    endcase
  end

  int              wr_cnt = 0;
  logic [1:0]      wr_cmd;
  logic [XLEN-1:0] wr_wd;
  logic [11:0]     wr_wa;
  int              ret_cnt = 0;

  always @(negedge clk) begin
    if (csr_wcmd != C_NONE) begin
      wr_cnt++;
      wr_cmd = csr_wcmd;
      wr_wd  = csr_wd;
      wr_wa  = csr_wa;
    end
  end

  always @(posedge clk) if (retire) ret_cnt++;

  typedef struct {
    bit          ill;
    bit          we;
    logic [4:0]  rd;
    logic [63:0] data;
    int          lat;
    logic [1:0]  cmd;
    logic [63:0] wd;
    int          nwr;
    logic [11:0] csr;
    logic [63:0] newval;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_req(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] idx,
                        input logic [63:0] val, input logic [4:0] rd, input logic [1:0] mode,
                        input int hold, input string name);
    exp_t        e;
    exp_t        g;
    bit          due, ill, skip;
    logic [63:0] opnd, old;
    int          lat, r0;
    due  = (f3[1:0] == 2'b01) || (idx != 5'd0);
    ill  = (f3[1:0] == 2'b00) || (csr[9:8] > mode) || ((csr[11:10] == 2'b11) && due);
    skip = (f3[1:0] == 2'b01) && (rd == 5'd0);
    opnd = f3[2] ? {59'b0, idx} : val;
    old  = csr_mem[csr];
    e.ill  = ill;
    e.we   = !ill && !skip && (rd != 5'd0);
    e.rd   = rd;
    e.data = (ill || skip) ? 64'd0 : old;
    e.lat  = ill ? 1 : (skip ? 2 : 3);
    e.nwr  = (!ill && due) ? 1 : 0;
    case (f3[1:0])
      2'b01:   e.cmd = C_WRITE;
      2'b10:   e.cmd = C_SET;
      default: e.cmd = C_CLEAR;
    endcase
    e.wd  = opnd;
    e.csr = csr;
    if (ill || !due)          e.newval = old;
    else if (f3[1:0] == 2'b01) e.newval = opnd;
    else if (f3[1:0] == 2'b10) e.newval = old | opnd;
    else                       e.newval = old & ~opnd;

    @(negedge clk);
    wr_cnt      = 0;
    r0          = ret_cnt;
    req_funct3  = f3;
    req_csr     = csr;
    req_rs1_idx = idx;
    req_rs1_val = val;
    req_rd_idx  = rd;
    req_mode    = mode;
    req_valid   = 1'b1;
    #1 chk({name, "/req_ready"}, req_ready, 1);
    @(posedge clk);
    sb.push_back(e);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    g = sb.pop_front();
    chk({name, "/latency"}, lat, g.lat);
    chk({name, "/illegal"}, rsp_illegal, g.ill);
    chk({name, "/we"}, rsp_we, g.we);
    chk({name, "/rd_idx"}, rsp_rd_idx, g.rd);
    chk({name, "/data"}, rsp_data, g.data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "/hold_valid"}, rsp_valid, 1);
      chk({name, "/hold_data"}, rsp_data, g.data);
      chk({name, "/hold_req_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    #1 chk({name, "/retire"}, retire, !g.ill);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "/retire_cnt"}, ret_cnt - r0, g.ill ? 0 : 1);
    chk({name, "/rsp_valid_clr"}, rsp_valid, 0);
    chk({name, "/req_ready_back"}, req_ready, 1);
    chk({name, "/wr_cnt"}, wr_cnt, g.nwr);
    if (g.nwr == 1) begin
      chk({name, "/wcmd"}, wr_cmd, g.cmd);
      chk({name, "/wd"}, wr_wd, g.wd);
      chk({name, "/wa"}, wr_wa, g.csr);
    end
    chk({name, "/csr_after"}, csr_mem[g.csr], g.newval);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [2:0] f3_tab [6];
    int         cyc;
    f3_tab[0] = 3'b001; f3_tab[1] = 3'b010; f3_tab[2] = 3'b011;
    f3_tab[3] = 3'b101; f3_tab[4] = 3'b110; f3_tab[5] = 3'b111;
    req_valid = 1'b0; req_funct3 = '0; req_csr = '0; req_rs1_idx = '0;
    req_rs1_val = '0; req_rd_idx = '0; req_mode = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
    csr_mem[12'h305] = 64'h100;
    csr_mem[12'h300] = 64'h1800;
    csr_mem[12'hC00] = 64'h1234;
    csr_mem[12'hF14] = 64'h7;
    csr_mem[12'h340] = 64'hFF;

    repeat (3) @(negedge clk);
    chk("rst/req_ready", req_ready, 0);
    chk("rst/rsp_valid", rsp_valid, 0);
    chk("rst/wcmd", csr_wcmd, C_NONE);
    chk("rst/ra", csr_ra, 0);
    chk("rst/wa", csr_wa, 0);
    chk("rst/wd", csr_wd, 0);
    chk("rst/rsp_data", rsp_data, 0);
    chk("rst/rsp_flags", {rsp_we, rsp_illegal, retire, rsp_rd_idx}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    do_req(3'b001, 12'h305, 5'd1, 64'h8000_0000, 5'd5, M_M, 0, "csrrw_mtvec");
    do_req(3'b110, 12'h300, 5'd8, 64'hDEAD, 5'd3, M_M, 0, "csrrsi_mstatus");
    do_req(3'b010, 12'hC00, 5'd0, 64'hFFFF, 5'd7, M_U, 0, "csrrs_cycle");
    do_req(3'b001, 12'h300, 5'd2, 64'h1, 5'd4, M_S, 0, "ill_priv");
    do_req(3'b001, 12'hF14, 5'd2, 64'h1, 5'd4, M_M, 0, "ill_ro");
    do_req(3'b011, 12'h340, 5'd2, 64'hF0, 5'd4, M_M, 0, "csrrc_mscratch");
    do_req(3'b101, 12'h340, 5'h1F, 64'h0, 5'd0, M_M, 0, "csrrwi_rd0");
    do_req(3'b000, 12'h340, 5'd1, 64'h1, 5'd1, M_M, 0, "ill_f3_000");
    do_req(3'b100, 12'h340, 5'd1, 64'h1, 5'd1, M_M, 0, "ill_f3_100");
    do_req(3'b010, 12'hF14, 5'd0, 64'h0, 5'd1, M_M, 0, "csrrs_mhartid");
    do_req(3'b111, 12'h340, 5'd0, 64'h0, 5'd0, M_M, 0, "csrrci_rd0");
    do_req(3'b001, 12'h305, 5'd1, 64'h200, 5'd6, M_M, 4, "hold");
    for (int i = 0; i < 8; i++) begin
      do_req(f3_tab[$urandom_range(0, 5)], (i % 2 == 0) ? 12'h340 : 12'h305,
             5'($urandom_range(0, 31)), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
             M_M, i % 3, "rand");
    end

    csr_mem[12'h340] = 64'hAAAA;
    @(negedge clk);
    req_funct3 = 3'b001; req_csr = 12'h340; req_rs1_idx = 5'd1;
    req_rs1_val = 64'h5555; req_rd_idx = 5'd6; req_mode = M_M; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (csr_wcmd == C_NONE && cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst/wcmd_seen", csr_wcmd, C_WRITE);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst/wcmd", csr_wcmd, C_NONE);
    chk("midrst/req_ready", req_ready, 0);
    chk("midrst/rsp_valid", rsp_valid, 0);
    chk("midrst/wa_wd", {csr_wa, csr_wd}, 0);
    @(posedge clk);
    #1;
    chk("midrst/no_write", csr_mem[12'h340], 64'hAAAA);
    rst_n = 1'b1;
    do_req(3'b010, 12'h340, 5'd0, 64'h0, 5'd9, M_M, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
